// File: rtl/dm_pkg.sv
// Shared types and constants for the MEM-stage data-memory responder.
package dm_pkg;

   localparam int       DM_ADDR_W  = 14;
   localparam logic [3:0] DM_WE_NONE = 4'b1111;

   typedef enum logic {
      DM_INIT,
      DM_READY
   } dm_state_t;

   // Write-first merge: enabled lanes (active-low) take the new byte, others keep the old.
   function automatic logic [31:0] dm_merge(input logic [31:0] old_word,
                                            input logic [31:0] new_word,
                                            input logic [3:0]  we_n);
      logic [31:0] merged;
      merged = old_word;
      for (int i = 0; i < 4; i++) begin
         if (!we_n[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/dm_sram_ctrl_if.sv
// MEM-stage to data-memory bus: address, byte enables, write data, clear and read-back.
interface dm_sram_ctrl_if
   import dm_pkg::*;
#(
   parameter int ADDR_W = DM_ADDR_W
);
   logic [ADDR_W-1:0] DM_addr;
   logic [3:0]        DM_write_en;
   logic [31:0]       DM_data_in;
   logic              clear_req;
   logic [31:0]       DM_data_out;
   logic              dm_ready;

   modport master (
      output DM_addr, DM_write_en, DM_data_in, clear_req,
      input  DM_data_out, dm_ready
   );

   modport slave (
      input  DM_addr, DM_write_en, DM_data_in, clear_req,
      output DM_data_out, dm_ready
   );
endinterface

// File: rtl/dm_byte_bank.sv
// One byte lane of the data memory: synchronous single-port array, read-first, active-low write.
module dm_byte_bank
   import dm_pkg::*;
#(
   parameter int ADDR_W = DM_ADDR_W
) (
   input  logic              clk,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic              we_n_i,
   input  logic [7:0]        wdata_i,
   output logic [7:0]        rdata_o
);
   logic [7:0] mem_q [2**ADDR_W];
   logic [7:0] rdata_q;

   // NOTE: the array and its read register carry no reset so the bank maps onto SRAM macros;
   // nonblocking assignments make the read return the pre-write contents.
   always_ff @(posedge clk) begin
      if (!we_n_i) mem_q[addr_i] <= wdata_i;
      rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/dm_sram_ctrl.sv
// Data-memory responder: four byte banks, zero-fill init engine and write-first read port.
module dm_sram_ctrl
   import dm_pkg::*;
#(
   parameter int ADDR_W        = DM_ADDR_W,
   parameter bit INIT_ON_RESET = 1'b1
) (
   input logic           clk,
   input logic           rst,
   dm_sram_ctrl_if.slave bus
);
   localparam dm_state_t RESET_STATE = INIT_ON_RESET ? DM_INIT : DM_READY;

   dm_state_t         state_q;
   logic [ADDR_W:0]   init_cnt_q;
   logic [ADDR_W:0]   init_cnt_d;
   logic              rd_valid_q;
   logic [3:0]        byp_we_n_q;
   logic [31:0]       byp_data_q;

   logic [ADDR_W-1:0] bank_addr;
   logic [3:0]        bank_we_n;
   logic [31:0]       bank_wdata;
   logic [31:0]       bank_rdata;
   logic [31:0]       data_out;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      init_cnt_d = init_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
      bank_addr  = bus.DM_addr;
      bank_we_n  = bus.DM_write_en;
      bank_wdata = bus.DM_data_in;
      if (state_q == DM_INIT) begin
         bank_addr  = init_cnt_q[ADDR_W-1:0];
         bank_we_n  = 4'b0000;
         bank_wdata = '0;
      end
   end

   for (genvar i = 0; i < 4; i++) begin : g_lane
      dm_byte_bank #(.ADDR_W(ADDR_W)) u_bank (
         .clk     (clk),
         .addr_i  (bank_addr),
         .we_n_i  (bank_we_n[i]),
         .wdata_i (bank_wdata[8*i +: 8]),
         .rdata_o (bank_rdata[8*i +: 8])
      );
   end

   // The MSB of init_cnt_d flags that the last word is being written this cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= RESET_STATE;
         init_cnt_q <= '0;
         rd_valid_q <= 1'b0;
         byp_we_n_q <= DM_WE_NONE;
         byp_data_q <= '0;
      end else begin
         case (state_q)
            DM_INIT: begin
               rd_valid_q <= 1'b0;
               byp_we_n_q <= DM_WE_NONE;
               if (init_cnt_d[ADDR_W]) begin
                  state_q    <= DM_READY;
                  init_cnt_q <= '0;
               end else begin
                  init_cnt_q <= init_cnt_d;
               end
            end
            DM_READY: begin
               rd_valid_q <= 1'b1;
               byp_we_n_q <= bus.DM_write_en;
               byp_data_q <= bus.DM_data_in;
               if (bus.clear_req) begin
                  state_q    <= DM_INIT;
                  init_cnt_q <= '0;
               end
            end
         endcase
      end
   end

   // Banks return pre-write data; the registered write lanes are overlaid here for write-first.
   always_comb begin
      data_out = '0;
      if (rd_valid_q) data_out = dm_merge(bank_rdata, byp_data_q, byp_we_n_q);
   end

   assign bus.DM_data_out = data_out;
   assign bus.dm_ready    = (state_q == DM_READY);
endmodule

// File: tb/tb_dm_sram_ctrl.sv
// Self-checking bench for dm_sram_ctrl with a 16-word array: vectors, corner sequences, random traffic.
module tb_dm_sram_ctrl;
   import dm_pkg::*;

   localparam int AW    = 4;
   localparam int DEPTH = 2**AW;

   typedef struct {
      logic [AW-1:0] addr;
      logic [3:0]    we;
      logic [31:0]   data;
      logic [31:0]   exp;
   } vec_t;

   logic clk;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [31:0] model_mem [DEPTH];
   vec_t        vecs [$];

   dm_sram_ctrl_if #(.ADDR_W(AW)) bus ();

   dm_sram_ctrl #(.ADDR_W(AW), .INIT_ON_RESET(1'b1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   function automatic vec_t mk(input logic [AW-1:0] a, input logic [3:0] we,
                               input logic [31:0] d, input logic [31:0] e);
      vec_t v;
      v.addr = a; v.we = we; v.data = d; v.exp = e;
      return v;
   endfunction

   // Reference behaviour: a word array updated lane by lane; the read sees the updated word.
   function automatic logic [31:0] model_access(input int a, input logic [3:0] we, input logic [31:0] d);
      for (int b = 0; b < 4; b++) begin
         if (we[b] == 1'b0) model_mem[a][8*b +: 8] = d[8*b +: 8];
      end
      return model_mem[a];
   endfunction

   function automatic void model_clear();
      for (int a = 0; a < DEPTH; a++) model_mem[a] = 32'h0;
   endfunction

   task automatic idle();
      bus.DM_addr     = '0;
      bus.DM_write_en = DM_WE_NONE;
      bus.DM_data_in  = '0;
      bus.clear_req   = 1'b0;
   endtask

   task automatic access(input logic [AW-1:0] a, input logic [3:0] we, input logic [31:0] d,
                         input logic clr, output logic [31:0] got);
      bus.DM_addr     = a;
      bus.DM_write_en = we;
      bus.DM_data_in  = d;
      bus.clear_req   = clr;
      @(posedge clk);
      #1;
      got = bus.DM_data_out;
      idle();
   endtask

   // Counts edges until dm_ready, throwing junk port traffic that must be dropped during init.
   task automatic wait_ready(output int n, output logic out_bad);
      n = 0;
      out_bad = 1'b0;
      while (!bus.dm_ready && n < 100) begin
         bus.DM_addr     = AW'($urandom_range(0, DEPTH-1));
         bus.DM_write_en = 4'($urandom_range(0, 15));
         bus.DM_data_in  = $urandom;
         bus.clear_req   = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         n++;
         if (bus.DM_data_out !== 32'h0) out_bad = 1'b1;
      end
      idle();
   endtask

   task automatic read_all_zero(input string name);
      logic [31:0] got;
      for (int a = 0; a < DEPTH; a++) begin
         access(AW'(a), DM_WE_NONE, 32'h0, 1'b0, got);
         check($sformatf("%s[%0d]", name, a), got, 32'h0);
      end
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] exp;
      logic        bad;
      logic        clr;
      logic [3:0]  we;
      logic [AW-1:0] a;
      logic [31:0] d;
      int          n;

      idle();
      model_clear();
      rst = 1'b0;
      #2;
      check("reset_data_out", bus.DM_data_out, 32'h0);
      check("reset_ready", 32'(bus.dm_ready), 32'h0);
      @(posedge clk);
      #3 rst = 1'b1;

      wait_ready(n, bad);
      check("init_len_after_reset", n, 16);
      check("init_data_out_zero", 32'(bad), 32'h0);
      read_all_zero("post_reset_rd");

      vecs.push_back(mk(4'd5, 4'b0000, 32'hDEADBEEF, 32'hDEADBEEF));
      vecs.push_back(mk(4'd5, 4'b1111, 32'h0,        32'hDEADBEEF));
      vecs.push_back(mk(4'd5, 4'b1101, 32'h0000AA00, 32'hDEADAAEF));
      vecs.push_back(mk(4'd5, 4'b1111, 32'h0,        32'hDEADAAEF));
      vecs.push_back(mk(4'd7, 4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF));
      vecs.push_back(mk(4'd7, 4'b0011, 32'h12340000, 32'h1234FFFF));
      vecs.push_back(mk(4'd7, 4'b1111, 32'h0,        32'h1234FFFF));
      vecs.push_back(mk(4'd1, 4'b0000, 32'h11111111, 32'h11111111));
      vecs.push_back(mk(4'd2, 4'b1111, 32'h0,        32'h00000000));
      vecs.push_back(mk(4'd2, 4'b0000, 32'h22222222, 32'h22222222));
      vecs.push_back(mk(4'd1, 4'b1111, 32'h0,        32'h11111111));
      vecs.push_back(mk(4'd1, 4'b1110, 32'h000000C3, 32'h111111C3));
      vecs.push_back(mk(4'd2, 4'b1111, 32'h0,        32'h22222222));
      vecs.push_back(mk(4'd1, 4'b1111, 32'h0,        32'h111111C3));
      vecs.push_back(mk(4'd9, 4'b0000, 32'h01020304, 32'h01020304));
      vecs.push_back(mk(4'd9, 4'b0101, 32'hAABBCCDD, 32'hAA02CC04));
      vecs.push_back(mk(4'd9, 4'b1111, 32'h0,        32'hAA02CC04));

      foreach (vecs[i]) begin
         access(vecs[i].addr, vecs[i].we, vecs[i].data, 1'b0, got);
         void'(model_access(int'(vecs[i].addr), vecs[i].we, vecs[i].data));
         check($sformatf("vec%0d", i), got, vecs[i].exp);
      end

      // clear_req with a same-cycle word write to addr 3
      access(4'd3, 4'b0000, 32'hCAFEF00D, 1'b1, got);
      check("clear_cycle_write", got, 32'hCAFEF00D);
      check("clear_ready_drop", 32'(bus.dm_ready), 32'h0);
      wait_ready(n, bad);
      check("init_len_after_clear", n, 16);
      check("clear_data_out_zero", 32'(bad), 32'h0);
      model_clear();
      access(4'd3, DM_WE_NONE, 32'h0, 1'b0, got);
      check("addr3_after_clear", got, 32'h0);
      read_all_zero("post_clear_rd");

      for (int c = 0; c < 400; c++) begin
         a   = AW'($urandom_range(0, DEPTH-1));
         we  = 4'($urandom_range(0, 15));
         d   = $urandom;
         clr = ($urandom_range(0, 59) == 0);
         access(a, we, d, clr, got);
         exp = model_access(int'(a), we, d);
         check($sformatf("rand%0d", c), got, exp);
         if (clr) begin
            check($sformatf("rand%0d_ready_drop", c), 32'(bus.dm_ready), 32'h0);
            wait_ready(n, bad);
            check($sformatf("rand%0d_init_len", c), n, 16);
            check($sformatf("rand%0d_init_out", c), 32'(bad), 32'h0);
            model_clear();
         end
      end
      for (int k = 0; k < DEPTH; k++) begin
         access(AW'(k), DM_WE_NONE, 32'h0, 1'b0, got);
         check($sformatf("final_rd[%0d]", k), got, model_mem[k]);
      end

      // Asynchronous reset in READY, then a second reset that aborts the fill at word 9
      access(4'd12, 4'b0000, 32'h5A5A5A5A, 1'b0, got);
      check("pre_reset_write", got, 32'h5A5A5A5A);
      #1 rst = 1'b0;
      #1;
      check("async_reset_data_out", bus.DM_data_out, 32'h0);
      check("async_reset_ready", 32'(bus.dm_ready), 32'h0);
      @(posedge clk);
      #3 rst = 1'b1;
      for (int k = 0; k < 9; k++) begin
         @(posedge clk);
         #1;
      end
      check("ready_low_mid_init", 32'(bus.dm_ready), 32'h0);
      rst = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #3 rst = 1'b1;
      wait_ready(n, bad);
      check("init_len_after_abort", n, 16);
      check("abort_data_out_zero", 32'(bad), 32'h0);
      read_all_zero("post_abort_rd");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
